// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings and the
// saturating rescale helper used by every lane.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_e;

    localparam int SAT_CALC_W = 64;

    // Floors toward -inf via arithmetic shift, then clamps into a signed out_w range.
    function automatic logic signed [SAT_CALC_W-1:0] sat_shift(
        input  logic signed [SAT_CALC_W-1:0] a,
        input  int                           shift,
        input  int                           out_w,
        output logic                         sat
    );
        logic signed [SAT_CALC_W-1:0] y;
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        y   = a >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        sat = 1'b0;
        if (y > hi) begin
            y   = hi;
            sat = 1'b1;
        end else if (y < lo) begin
            y   = lo;
            sat = 1'b1;
        end
        return y;
    endfunction

endpackage

// File: rtl/act_unit_pipe_if.sv
// Stream interface carrying the input beat (data plus per-beat controls) and
// the output beat of the activation pipeline.
interface act_unit_pipe_if #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 24,
    parameter int OUT_W    = 16
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*IN_W-1:0]  in_data;
    logic [1:0]                mode;
    logic [3:0]                leak_shift;
    logic [OUT_W-1:0]          clip_val;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, mode, leak_shift, clip_val, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, mode, leak_shift, clip_val, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/act_lane.sv
// One lane slice: the activation half feeds S1, the rescale/saturate/clip half
// works on the S1 register contents and feeds S2.
module act_lane
    import act_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  i_x,
    input  act_mode_e               i_mode,
    input  logic [3:0]              i_leak_shift,
    output logic signed [IN_W:0]    o_act,
    input  logic signed [IN_W:0]    i_act,
    input  act_mode_e               i_s2_mode,
    input  logic [OUT_W-1:0]        i_clip,
    output logic signed [OUT_W-1:0] o_y,
    output logic                    o_sat
);

    logic signed [IN_W:0]            w_x_ext;
    logic signed [SAT_CALC_W-1:0]    w_y;
    logic signed [SAT_CALC_W-1:0]    w_clip_ext;
    logic                            w_sat;

    always_comb begin
        w_x_ext = {i_x[IN_W-1], i_x};
        o_act   = w_x_ext;
        if (i_x[IN_W-1]) begin
            case (i_mode)
                ACT_RELU, ACT_CLIP: o_act = '0;
                ACT_LEAKY:          o_act = w_x_ext >>> i_leak_shift;
                default:            o_act = w_x_ext;
            endcase
        end
    end

    // The clip ceiling is applied after saturation and never counts as a saturation.
    always_comb begin
        w_sat      = 1'b0;
        w_clip_ext = {{(SAT_CALC_W-OUT_W){1'b0}}, i_clip};
        w_y        = sat_shift({{(SAT_CALC_W-IN_W-1){i_act[IN_W]}}, i_act}, SHIFT, OUT_W, w_sat);
        if (i_s2_mode == ACT_CLIP && w_y > w_clip_ext) begin
            w_y = w_clip_ext;
        end
        o_y   = w_y[OUT_W-1:0];
        o_sat = w_sat;
    end

endmodule

// File: rtl/act_unit_pipe.sv
// Two-stage valid/ready activation pipeline: S1 holds activated lanes plus the
// beat's controls, S2 holds rescaled output lanes; counts saturated lanes.
module act_unit_pipe
    import act_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 24,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] sat_count,
    act_unit_pipe_if.slave   bus
);

    logic                      w_s2_load;
    logic                      w_s1_load;
    act_mode_e                 w_in_mode;
    logic signed [IN_W:0]      w_act [CHANNELS];
    logic [CHANNELS*OUT_W-1:0] w_y;
    logic [CHANNELS-1:0]       w_sat;
    logic [CNT_W:0]            w_sat_add;
    logic [CNT_W:0]            w_cnt_sum;
    logic [CNT_W-1:0]          w_cnt_next;

    logic                      r_s1_valid;
    logic signed [IN_W:0]      r_s1_act [CHANNELS];
    act_mode_e                 r_s1_mode;
    logic [OUT_W-1:0]          r_s1_clip;
    logic                      r_s2_valid;
    logic [CHANNELS*OUT_W-1:0] r_s2_data;
    logic [CNT_W-1:0]          r_sat_count;

    assign w_s2_load     = !r_s2_valid || bus.out_ready;
    assign w_s1_load     = !r_s1_valid || w_s2_load;
    assign w_in_mode     = act_mode_e'(bus.mode);
    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign sat_count     = r_sat_count;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        act_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_lane (
            .i_x          (bus.in_data[g*IN_W +: IN_W]),
            .i_mode       (w_in_mode),
            .i_leak_shift (bus.leak_shift),
            .o_act        (w_act[g]),
            .i_act        (r_s1_act[g]),
            .i_s2_mode    (r_s1_mode),
            .i_clip       (r_s1_clip),
            .o_y          (w_y[g*OUT_W +: OUT_W]),
            .o_sat        (w_sat[g])
        );
    end

    always_comb begin
        w_sat_add = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sat_add = w_sat_add + (CNT_W+1)'(w_sat[i]);
        end
        w_cnt_sum  = {1'b0, r_sat_count} + w_sat_add;
        w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= ACT_IDENT;
            r_s1_clip  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_s1_act[i] <= '0;
            end
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_mode <= w_in_mode;
                r_s1_clip <= bus.clip_val;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_s1_act[i] <= w_act[i];
                end
            end
        end
    end

    // Output holds while stalled; the counter only sees beats that actually enter S2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_y;
                end
            end
            if (clear_stats) begin
                r_sat_count <= '0;
            end else if (w_s2_load && r_s1_valid) begin
                r_sat_count <= w_cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Directed bench for act_unit_pipe: a queue scoreboard fed by an arithmetic
// reference model, plus directed checks of latency, stalls, stats and reset.
module tb_act_unit_pipe;

    localparam int CH    = 4;
    localparam int IN_W  = 24;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             clear_stats;
    logic [CNT_W-1:0] sat_count;

    act_unit_pipe_if #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    act_unit_pipe #(
        .CHANNELS (CH),
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SHIFT    (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear_stats (clear_stats),
        .sat_count   (sat_count),
        .bus         (bus.slave)
    );

    int          total = 0;
    int          bad = 0;
    int          outCount = 0;
    int          stalls = 0;
    longint      expSat = 0;
    logic [63:0] expQ[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint floorDiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [95:0] packIn(input int l0, input int l1, input int l2, input int l3);
        logic [95:0] r;
        r[23:0]  = l0[23:0];
        r[47:24] = l1[23:0];
        r[71:48] = l2[23:0];
        r[95:72] = l3[23:0];
        return r;
    endfunction

    // Reference: activation, floor division by 16, clamp to int16, optional ceiling.
    function automatic logic [63:0] modelBeat(input logic [95:0] d, input logic [1:0] m,
                                              input logic [3:0] ls, input logic [15:0] clip,
                                              output int nsat);
        logic [63:0] r;
        logic [23:0] raw;
        longint      x;
        longint      a;
        longint      y;
        nsat = 0;
        r = '0;
        for (int i = 0; i < CH; i++) begin
            raw = d[i*24 +: 24];
            x = $signed(raw);
            a = x;
            if (x < 0) begin
                if (m == 2'd1 || m == 2'd3) a = 0;
                else if (m == 2'd2) a = floorDiv(x, longint'(1) << ls);
            end
            y = floorDiv(a, 16);
            if (y > 32767) begin
                y = 32767;
                nsat++;
            end else if (y < -32768) begin
                y = -32768;
                nsat++;
            end
            if (m == 2'd3 && y > longint'(clip)) y = longint'(clip);
            r[i*16 +: 16] = y[15:0];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a beat (called just after a rising edge) and returns just after the accepting edge.
    task automatic applyStimulus(input logic [95:0] d, input logic [1:0] m,
                                 input logic [3:0] ls, input logic [15:0] clip);
        int          waits;
        int          nsat;
        logic [63:0] e;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.mode       = m;
        bus.leak_shift = ls;
        bus.clip_val   = clip;
        waits = 0;
        @(negedge clock);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            stalls++;
            @(negedge clock);
        end
        if (waits >= 50) begin
            total++;
            bad++;
            $error("[TB] FAIL accept_timeout observed=%0d expected<50", waits);
        end
        e = modelBeat(d, m, ls, clip, nsat);
        expQ.push_back(e);
        expSat = (expSat + nsat > 65535) ? 65535 : expSat + nsat;
        @(posedge clock);
        #1;
    endtask

    task automatic directedBeat(input string tag, input logic [95:0] d, input logic [1:0] m,
                                input logic [3:0] ls, input logic [15:0] clip,
                                input logic [63:0] expected);
        int c;
        applyStimulus(d, m, ls, clip);
        bus.in_valid = 1'b0;
        c = 0;
        @(negedge clock);
        while (!bus.out_valid && c < 5) begin
            c++;
            @(negedge clock);
        end
        checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput(tag, bus.out_data, expected);
        @(posedge clock);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        int c;
        bus.in_valid = 1'b0;
        c = 0;
        while ((expQ.size() > 0 || bus.out_valid) && c < 100) begin
            @(posedge clock);
            c++;
        end
        #1;
        checkOutput({tag, "_drain"}, 64'(expQ.size()), 64'd0);
    endtask

    // Scoreboard: every completed output transfer is compared against the oldest expectation.
    always @(negedge clock) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            total++;
            assert (expQ.size() > 0) else begin
                bad++;
                $error("[TB] FAIL sb_unexpected observed=%0h expected=none", bus.out_data);
            end
            if (expQ.size() > 0) begin
                logic [63:0] e;
                e = expQ.pop_front();
                outCount++;
                total++;
                assert (bus.out_data === e) else begin
                    bad++;
                    $error("[TB] FAIL sb_data observed=%0h expected=%0h", bus.out_data, e);
                end
            end
        end
    end

    logic [95:0] bp[6];
    logic [1:0]  bpm[6];
    logic [3:0]  bpl[6];
    logic [15:0] bpc[6];
    logic [63:0] held;
    logic [63:0] eb1;
    int          nsDummy;
    int          stallsBefore;
    int          outBefore;
    logic [95:0] satAll;

    initial begin
        reset          = 1'b0;
        clear_stats    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.mode       = 2'd0;
        bus.leak_shift = 4'd0;
        bus.clip_val   = '0;
        bus.out_ready  = 1'b1;
        #2;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_data", bus.out_data, 64'd0);
        checkOutput("rst_sat_count", 64'(sat_count), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] relu beat and latency");
        applyStimulus(packIn(-5, 4660, 0, -8388608), 2'd1, 4'd0, 16'd0);
        bus.in_valid = 1'b0;
        @(negedge clock);
        checkOutput("lat_first_cycle", 64'(bus.out_valid), 64'd0);
        @(negedge clock);
        checkOutput("lat_second_cycle", 64'(bus.out_valid), 64'd1);
        checkOutput("relu_data", bus.out_data, 64'h0000_0000_0123_0000);
        @(posedge clock);
        #1;
        waitDrain("relu");
        checkOutput("relu_sat", 64'(sat_count), 64'd0);

        $display("[TB] leaky and identity floor");
        directedBeat("leaky", packIn(-256, 160, 0, 0), 2'd2, 4'd2, 16'd0, 64'h0000_0000_000A_FFFC);
        directedBeat("ident_floor", packIn(-17, 0, 0, 0), 2'd0, 4'd0, 16'd0, 64'h0000_0000_0000_FFFE);
        waitDrain("leaky");

        $display("[TB] saturation and stats clear");
        directedBeat("sat_data", packIn(24'h7FFFFF, 24'h800000, 16, -16), 2'd0, 4'd0, 16'd0,
                     64'hFFFF_0001_8000_7FFF);
        checkOutput("sat_count_2", 64'(sat_count), 64'd2);
        waitDrain("sat");
        applyStimulus(packIn(24'h7FFFFF, 24'h800000, 16, -16), 2'd0, 4'd0, 16'd0);
        bus.in_valid = 1'b0;
        clear_stats  = 1'b1;
        @(posedge clock);
        #1;
        clear_stats = 1'b0;
        expSat = 0;
        checkOutput("clr_beat_loaded", 64'(bus.out_valid), 64'd1);
        checkOutput("clr_priority", 64'(sat_count), 64'd0);
        waitDrain("clr");

        $display("[TB] clipped relu");
        directedBeat("clip_data", packIn(4000, 1600, -50, 1599), 2'd3, 4'd0, 16'd100,
                     64'h0063_0000_0064_0064);
        waitDrain("clip");
        checkOutput("clip_sat", 64'(sat_count), 64'd0);

        $display("[TB] backpressure");
        bp[0] = packIn(100, -100, 5000, -5000);  bpm[0] = 2'd0; bpl[0] = 4'd0;  bpc[0] = 16'd0;
        bp[1] = packIn(-64, 64, 320, -320);      bpm[1] = 2'd2; bpl[1] = 4'd3;  bpc[1] = 16'd0;
        bp[2] = packIn(1000, 2000, -1, 3000);    bpm[2] = 2'd3; bpl[2] = 4'd0;  bpc[2] = 16'd150;
        bp[3] = packIn(-33, 33, 0, 48);          bpm[3] = 2'd1; bpl[3] = 4'd0;  bpc[3] = 16'd0;
        bp[4] = packIn(7, -7, 1600, -1600);      bpm[4] = 2'd0; bpl[4] = 4'd0;  bpc[4] = 16'd0;
        bp[5] = packIn(-4096, 4096, 8, -8);      bpm[5] = 2'd2; bpl[5] = 4'd15; bpc[5] = 16'd0;
        eb1 = modelBeat(bp[0], bpm[0], bpl[0], bpc[0], nsDummy);
        outBefore = outCount;
        bus.out_ready = 1'b0;
        applyStimulus(bp[0], bpm[0], bpl[0], bpc[0]);
        applyStimulus(bp[1], bpm[1], bpl[1], bpc[1]);
        bus.in_valid = 1'b0;
        held = bus.out_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            checkOutput("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
            checkOutput("bp_data_stable", bus.out_data, held);
            @(posedge clock);
            #1;
        end
        checkOutput("bp_held_is_first", held, eb1);
        bus.out_ready = 1'b1;
        stallsBefore = stalls;
        for (int k = 2; k < 6; k++) begin
            applyStimulus(bp[k], bpm[k], bpl[k], bpc[k]);
        end
        checkOutput("bp_throughput", 64'(stalls - stallsBefore), 64'd0);
        waitDrain("bp");
        checkOutput("bp_out_count", 64'(outCount - outBefore), 64'd6);
        checkOutput("bp_sat", 64'(sat_count), 64'(expSat));

        $display("[TB] reset mid-stream");
        satAll = packIn(24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000);
        bus.out_ready = 1'b0;
        applyStimulus(satAll, 2'd0, 4'd0, 16'd0);
        applyStimulus(satAll, 2'd0, 4'd0, 16'd0);
        bus.in_valid = 1'b0;
        checkOutput("pre_rst_sat", 64'(sat_count), 64'd4);
        checkOutput("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_rst_sat", 64'(sat_count), 64'd0);
        checkOutput("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        expQ.delete();
        expSat = 0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(packIn(320, -320, 0, 1), 2'd0, 4'd0, 16'd0);
        bus.in_valid = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_lat1", 64'(bus.out_valid), 64'd0);
        @(negedge clock);
        checkOutput("post_rst_lat2", 64'(bus.out_valid), 64'd1);
        checkOutput("post_rst_data", bus.out_data, 64'h0000_0000_FFEC_0014);
        @(posedge clock);
        #1;
        waitDrain("post_rst");

        $display("[TB] counter sticks at all-ones");
        for (int k = 0; k < 16390; k++) begin
            applyStimulus(satAll, 2'd0, 4'd0, 16'd0);
        end
        waitDrain("stick");
        checkOutput("sat_stick_model", 64'(sat_count), 64'(expSat));
        checkOutput("sat_stick_ones", 64'(sat_count), 64'hFFFF);

        checkOutput("sb_empty_end", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
